// File: rtl/decode_stage.sv
// RV base-ISA decode stage: combinational field/immediate decode, load-use
// hazard detection and a single ID/EX pipeline register with flush/backpressure.
module decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  pc,
    input  logic [31:0]      instr,
    input  logic             ex_ready,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_pc,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_func3,
    output logic [6:0]       out_func7,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_mem_read,
    output logic             out_illegal,
    output logic             hazard,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [6:0]      w_opcode;
    logic [2:0]      w_func3;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_shamt;
    logic            w_illegal;
    logic            w_rs1_used;
    logic            w_rs2_used;
    logic            w_capture;
    logic            w_bubble;

    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [6:0]       r_opcode;
    logic [2:0]       r_func3;
    logic [6:0]       r_func7;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic [XLEN-1:0]  r_imm;
    logic             r_mem_read;
    logic             r_illegal;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_opcode = instr[6:0];
    assign w_func3  = instr[14:12];

    // Shift amount field widens by one bit on RV64.
    generate
        if (XLEN == 64) begin : g_shamt64
            assign w_shamt = {{(XLEN-6){1'b0}}, instr[25:20]};
        end else begin : g_shamt32
            assign w_shamt = {{(XLEN-5){1'b0}}, instr[24:20]};
        end
    endgenerate

    // Immediate, legality and register-use decode from the raw instruction.
    always_comb begin
        w_imm      = '0;
        w_illegal  = 1'b0;
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b0;
        case (w_opcode)
            OP_IMM: begin
                if (w_func3 == 3'b001 || w_func3 == 3'b101) begin
                    w_imm = w_shamt;
                end else begin
                    w_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
                end
            end
            OP_LOAD, OP_JALR: w_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            OP_STORE: begin
                w_imm      = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
                w_rs2_used = 1'b1;
            end
            OP_BRANCH: begin
                w_imm      = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                              instr[30:25], instr[11:8], 1'b0};
                w_rs2_used = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                w_imm      = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
                w_rs1_used = 1'b0;
            end
            OP_JAL: begin
                w_imm      = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                              instr[20], instr[30:21], 1'b0};
                w_rs1_used = 1'b0;
            end
            OP_REG:              w_rs2_used = 1'b1;
            OP_FENCE, OP_SYSTEM: w_imm = '0;
            default:             w_illegal = 1'b1;
        endcase
    end

    // Load-use hazard: the registered load's destination feeds the incoming instruction.
    assign hazard = r_valid & r_mem_read & (r_rd != 5'd0) & in_valid &
                    ((w_rs1_used & (instr[19:15] == r_rd)) |
                     (w_rs2_used & (instr[24:20] == r_rd)));

    assign in_ready  = ex_ready & ~hazard;
    assign w_capture = ~flush & ex_ready & ~hazard & in_valid;
    assign w_bubble  = flush | (ex_ready & ~w_capture);

    // ID/EX register: flush > backpressure hold > hazard bubble > capture > idle bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_opcode   <= OP_REG;
            r_func3    <= 3'd0;
            r_func7    <= 7'd0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_rd       <= 5'd0;
            r_imm      <= '0;
            r_mem_read <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_bubble) begin
            r_valid    <= 1'b0;
            r_opcode   <= OP_REG;
            r_func3    <= 3'd0;
            r_func7    <= 7'd0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_rd       <= 5'd0;
            r_imm      <= '0;
            r_mem_read <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_capture) begin
            r_valid    <= 1'b1;
            r_pc       <= pc;
            r_opcode   <= w_opcode;
            r_func3    <= w_func3;
            r_func7    <= instr[31:25];
            r_rs1      <= instr[19:15];
            r_rs2      <= instr[24:20];
            r_rd       <= instr[11:7];
            r_imm      <= w_imm;
            r_mem_read <= (w_opcode == OP_LOAD);
            r_illegal  <= w_illegal;
        end
    end

    // Saturating count of hazard stall cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (hazard && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid    = r_valid;
    assign out_pc       = r_pc;
    assign out_opcode   = r_opcode;
    assign out_func3    = r_func3;
    assign out_func7    = r_func7;
    assign out_rs1      = r_rs1;
    assign out_rs2      = r_rs2;
    assign out_rd       = r_rd;
    assign out_imm      = r_imm;
    assign out_mem_read = r_mem_read;
    assign out_illegal  = r_illegal;
    assign stall_cnt    = r_stall_cnt;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/PC/immediate width; legal values 32, 64.
REQ-002 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  squash the instruction entering the ID/EX register.
REQ-006 SHALL have port in_valid  input  1  pc/instr from fetch are valid.
REQ-007 SHALL have port in_ready  output  1  decode accepts pc/instr this cycle.
REQ-008 SHALL have port pc  input  XLEN  address of instr.
REQ-009 SHALL have port instr  input  32  raw RV instruction.
REQ-010 SHALL have port ex_ready  input  1  execute stage accepts the registered output.
REQ-011 SHALL have port out_valid  output  1  ID/EX register holds a live instruction.
REQ-012 SHALL have ports out_pc (XLEN), out_opcode (7), out_func3 (3), out_func7 (7), out_rs1 (5), out_rs2 (5), out_rd (5), out_imm (XLEN), all outputs, registered decoded fields.
REQ-013 SHALL have port out_mem_read  output  1  registered instruction is a load (opcode 0000011).
REQ-014 SHALL have port out_illegal  output  1  registered opcode is not a recognised RV base opcode.
REQ-015 SHALL have port hazard  output  1  load-use stall, combinational.
REQ-016 SHALL have port stall_cnt  output  CNT_W  count of hazard stall cycles.

Function
REQ-017 SHALL compute the immediate combinationally from instr, sign-extended to XLEN from instr[31] unless stated otherwise.
REQ-018 SHALL decode immediates: I (0010011, 1100111, 0000011) = instr[31:20]; S (0100011) = {instr[31:25], instr[11:7]}; B (1100011) = {instr[31], instr[7], instr[30:25], instr[11:8], 0}; U (0110111, 0010111) = {instr[31:12], 12'b0}; J (1101111) = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-019 SHALL zero-extend the shift amount only for opcode 0010011 with func3 001/101: instr[24:20] when XLEN=32, instr[25:20] when XLEN=64; loads and JALR with func3 001/101 stay sign-extended.
REQ-020 SHALL use immediate 0 and flag illegal for all other opcodes besides 0110011, 0001111 and 1110011, which are legal with immediate 0; the decoder SHALL never drive X or Z.
REQ-021 SHALL treat rs1 as used for all opcodes except 0110111, 0010111 and 1101111.
REQ-022 SHALL treat rs2 as used only for 0110011, 0100011 and 1100011.
REQ-023 SHALL assert hazard = out_valid & out_mem_read & (out_rd != 0) & in_valid & ((rs1 used & instr[19:15] == out_rd) | (rs2 used & instr[24:20] == out_rd)).
REQ-024 SHALL drive in_ready = ex_ready & ~hazard.
REQ-025 SHALL apply ID/EX update priority at each edge: flush, then ~ex_ready, then hazard, then in_valid.
REQ-026 On flush, the ID/EX register SHALL load a bubble regardless of ex_ready; the input instruction SHALL be discarded.
REQ-027 On ~ex_ready without flush, the ID/EX register SHALL hold all fields unchanged.
REQ-028 On hazard with ex_ready, the ID/EX register SHALL load a bubble (exactly one bubble per load-use pair), and fetch SHALL hold pc/instr.
REQ-029 On in_valid & in_ready, the ID/EX register SHALL load the decoded fields with out_valid=1.
REQ-030 With ex_ready and no in_valid, the ID/EX register SHALL load a bubble.
REQ-031 A bubble SHALL be: out_valid=0, out_opcode=0110011, out_func3=0, out_func7=0, out_rs1/rs2/rd=0, out_imm=0, out_mem_read=0, out_illegal=0; out_pc holds its previous value.
REQ-032 SHALL increment stall_cnt on every edge where hazard=1, saturating at all-ones.
REQ-033 Latency: input to output SHALL be 1 cycle; throughput SHALL be 1 instruction/cycle absent hazard or backpressure.

Reset
REQ-034 On reset low, SHALL asynchronously force the ID/EX register to a bubble, out_pc=0 and stall_cnt=0.
REQ-035 When reset is asserted mid-stall, hazard SHALL fall within the same cycle because out_valid=0.
REQ-036 Release of reset SHALL be synchronous to clk, and the first capture SHALL occur at the first rising edge with reset high.

Verification
REQ-037 Bench SHALL check ADDI x1,x0,-1 (0xFFF00093), in_valid, ex_ready -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_rd=1.
REQ-038 Bench SHALL check LW x5,0(x2) followed by ADD x6,x5,x7 -> hazard=1 one cycle, in_ready=0, one bubble, ADD registers one cycle later, stall_cnt=1.
REQ-039 Bench SHALL check LW x0 followed by a use of x0, and LW x5 followed by LUI x5 -> hazard=0 in both.
REQ-040 Bench SHALL check ex_ready=0 for 3 cycles while in_valid=1 -> all outputs frozen, in_ready=0; flush during the freeze -> out_valid=0 next edge.
REQ-041 Bench SHALL check SRAI x1,x2,5 (0x40515093) -> out_imm=5, out_func7=0100000; LH with func3 001 and imm 0x800 -> out_imm=0xFFFFF800.
REQ-042 Bench SHALL check XLEN=64 with JAL offset -2 -> out_imm=0xFFFFFFFFFFFFFFFE; opcode 0000000 -> out_illegal=1, out_imm=0.
